// File: rtl/sq_opn_regs.sv
// OPN CPU register front end: decodes YM2203-style address/data writes into per-channel
// slot parameters. Define SQ_OPN_BUSY_EN to build the busy counter and busy-write dropping.
module sq_opn_regs #(
  parameter int unsigned BUSY_CYCLES = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic        a0,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [10:0] fnumber0,
  output logic [10:0] fnumber1,
  output logic [10:0] fnumber2,
  output logic [2:0]  block0,
  output logic [2:0]  block1,
  output logic [2:0]  block2,
  output logic [3:0]  multiple0,
  output logic [3:0]  multiple1,
  output logic [3:0]  multiple2,
  output logic [2:0]  keyon
);

  logic        r_cs_n, r_wr_n, r_wr_n_d, r_arm, r_a0;
  logic [7:0]  r_din;
  logic        r_evt, r_evt_a0;
  logic [7:0]  r_evt_din;
  logic [7:0]  r_addr;
  logic [5:0]  r_hi;
  logic [10:0] r_fnum [3];
  logic [2:0]  r_blk  [3];
  logic [3:0]  r_mul  [3];
  logic [2:0]  r_keyon;

  logic        w_evt, w_busy, w_addr_wr, w_data_wr;
  logic [1:0]  w_ch, w_key_ch;

  // Bus input stage; r_arm blocks the falling edge implied by wr_n held low through reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_wr_n_d <= 1'b1;
      r_arm    <= 1'b0;
      r_a0     <= 1'b0;
      r_din    <= 8'h00;
    end else begin
      r_cs_n   <= cs_n;
      r_wr_n   <= wr_n;
      r_wr_n_d <= r_wr_n;
      r_arm    <= r_arm | wr_n;
      r_a0     <= a0;
      r_din    <= din;
    end
  end

  assign w_evt = ~r_wr_n & r_wr_n_d & ~r_cs_n & r_arm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_evt     <= 1'b0;
      r_evt_a0  <= 1'b0;
      r_evt_din <= 8'h00;
    end else begin
      r_evt     <= w_evt;
      r_evt_a0  <= r_a0;
      r_evt_din <= r_din;
    end
  end

`ifdef SQ_OPN_BUSY_EN
  localparam int unsigned CntW = (BUSY_CYCLES == 0) ? 1 : $clog2(BUSY_CYCLES + 1);

  logic [CntW-1:0] r_busy_cnt;

  // Acceptance uses the pre-edge count, so a write on the edge reaching zero is still dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy_cnt <= '0;
    end else if (w_data_wr) begin
      r_busy_cnt <= CntW'(BUSY_CYCLES);
    end else if (r_busy_cnt != '0) begin
      r_busy_cnt <= r_busy_cnt - CntW'(1);
    end
  end

  assign w_busy = (r_busy_cnt != '0);
`else
  assign w_busy = 1'b0 & (BUSY_CYCLES != 0);
`endif

  assign w_addr_wr = r_evt & ~r_evt_a0;
  assign w_data_wr = r_evt & r_evt_a0 & ~w_busy;
  assign w_ch      = r_addr[1:0];
  assign w_key_ch  = r_evt_din[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= 8'h00;
      r_hi    <= 6'h00;
      r_keyon <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_fnum[i] <= 11'h000;
        r_blk[i]  <= 3'h0;
        r_mul[i]  <= 4'h0;
      end
    end else begin
      if (w_addr_wr) begin
        r_addr <= r_evt_din;
      end
      if (w_data_wr) begin
        if (r_addr inside {8'hA4, 8'hA5, 8'hA6}) begin
          r_hi <= r_evt_din[5:0];
        end else if (r_addr inside {8'hA0, 8'hA1, 8'hA2}) begin
          r_fnum[w_ch] <= {r_hi[2:0], r_evt_din};
          r_blk[w_ch]  <= r_hi[5:3];
        end else if (r_addr inside {8'h30, 8'h31, 8'h32}) begin
          r_mul[w_ch] <= r_evt_din[3:0];
        end else if (r_addr == 8'h28 && w_key_ch != 2'd3) begin
          r_keyon[w_key_ch] <= r_evt_din[4];
        end
      end
    end
  end

  assign dout      = {w_busy, 7'b000_0000};
  assign fnumber0  = r_fnum[0];
  assign fnumber1  = r_fnum[1];
  assign fnumber2  = r_fnum[2];
  assign block0    = r_blk[0];
  assign block1    = r_blk[1];
  assign block2    = r_blk[2];
  assign multiple0 = r_mul[0];
  assign multiple1 = r_mul[1];
  assign multiple2 = r_mul[2];
  assign keyon     = r_keyon;

endmodule

// File: tb/tb_sq_opn_regs.sv
// Randomised bench for sq_opn_regs against a transaction-level register model.
module tb_sq_opn_regs;

  localparam int Busy = 17;
`ifdef SQ_OPN_BUSY_EN
  localparam bit BusyEn = 1'b1;
`else
  localparam bit BusyEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, cs_n, wr_n, a0;
  logic [7:0]  din, dout;
  logic [10:0] fnumber0, fnumber1, fnumber2;
  logic [2:0]  block0, block1, block2;
  logic [3:0]  multiple0, multiple1, multiple2;
  logic [2:0]  keyon;

  sq_opn_regs #(.BUSY_CYCLES(Busy)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs_n      (cs_n),
    .wr_n      (wr_n),
    .a0        (a0),
    .din       (din),
    .dout      (dout),
    .fnumber0  (fnumber0),
    .fnumber1  (fnumber1),
    .fnumber2  (fnumber2),
    .block0    (block0),
    .block1    (block1),
    .block2    (block2),
    .multiple0 (multiple0),
    .multiple1 (multiple1),
    .multiple2 (multiple2),
    .keyon     (keyon)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int busy_seen = 0;

  typedef struct {
    int         apply;
    bit         a0;
    logic [7:0] d;
  } wr_t;
  wr_t pend[$];

  logic [7:0]  m_addr;
  logic [5:0]  m_hi;
  logic [10:0] m_fnum [3];
  logic [2:0]  m_blk  [3];
  logic [3:0]  m_mul  [3];
  logic [2:0]  m_key;
  int          m_load;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit busy_before(input int e);
    return BusyEn && e > m_load && e <= m_load + Busy;
  endfunction

  function automatic bit busy_after(input int e);
    return BusyEn && e >= m_load && e < m_load + Busy;
  endfunction

  task automatic m_reset();
    m_addr = 8'h00;
    m_hi   = 6'h00;
    m_key  = 3'b000;
    m_load = -1000;
    for (int i = 0; i < 3; i++) begin
      m_fnum[i] = 11'h000;
      m_blk[i]  = 3'h0;
      m_mul[i]  = 4'h0;
    end
    pend.delete();
  endtask

  task automatic m_apply(input bit wa0, input logic [7:0] d, input int e);
    int ch;
    if (!wa0) begin
      m_addr = d;
    end else if (!busy_before(e)) begin
      if (BusyEn) m_load = e;
      if (m_addr >= 8'hA4 && m_addr <= 8'hA6) begin
        m_hi = d[5:0];
      end else if (m_addr >= 8'hA0 && m_addr <= 8'hA2) begin
        ch = int'(m_addr) - 'hA0;
        m_fnum[ch] = {m_hi[2:0], d};
        m_blk[ch]  = m_hi[5:3];
      end else if (m_addr >= 8'h30 && m_addr <= 8'h32) begin
        ch = int'(m_addr) - 'h30;
        m_mul[ch] = d[3:0];
      end else if (m_addr == 8'h28 && d[1:0] != 2'd3) begin
        m_key[d[1:0]] = d[4];
      end
    end
  endtask

  // One clock: advance the model at the rising edge, compare everything at the falling edge.
  task automatic cycle();
    @(posedge clk);
    edge_cnt++;
    while (pend.size() > 0 && pend[0].apply == edge_cnt) begin
      m_apply(pend[0].a0, pend[0].d, edge_cnt);
      void'(pend.pop_front());
    end
    @(negedge clk);
    check_eq("dout", 32'(dout), busy_after(edge_cnt) ? 32'h80 : 32'h0);
    check_eq("fnumber0", 32'(fnumber0), 32'(m_fnum[0]));
    check_eq("fnumber1", 32'(fnumber1), 32'(m_fnum[1]));
    check_eq("fnumber2", 32'(fnumber2), 32'(m_fnum[2]));
    check_eq("block", 32'({block2, block1, block0}), 32'({m_blk[2], m_blk[1], m_blk[0]}));
    check_eq("multiple", 32'({multiple2, multiple1, multiple0}),
             32'({m_mul[2], m_mul[1], m_mul[0]}));
    check_eq("keyon", 32'(keyon), 32'(m_key));
    if (dout[7]) busy_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  // Called just after a falling edge; the pins are first sampled on the next rising edge.
  task automatic bus_wr(input bit wa0, input logic [7:0] d, input int hold, input bit sel);
    cs_n = ~sel;
    a0   = wa0;
    din  = d;
    wr_n = 1'b0;
    if (sel) pend.push_back('{edge_cnt + 3, wa0, d});
    repeat (hold) cycle();
    wr_n = 1'b1;
    cs_n = 1'b1;
    din  = 8'($urandom);
    cycle();
  endtask

  task automatic wr_pair(input logic [7:0] addr, input logic [7:0] d);
    bus_wr(1'b0, addr, 1, 1'b1);
    idle(2);
    bus_wr(1'b1, d, 1, 1'b1);
    idle(20);
  endtask

  logic [7:0] addr_tab [12];

  initial begin
    addr_tab = '{8'hA0, 8'hA1, 8'hA2, 8'hA4, 8'hA5, 8'hA6,
                 8'h30, 8'h31, 8'h32, 8'h28, 8'h28, 8'h00};
    reset_n = 1'b0;
    cs_n    = 1'b1;
    wr_n    = 1'b1;
    a0      = 1'b0;
    din     = 8'h00;
    m_reset();
    idle(3);
    reset_n = 1'b1;
    idle(3);
    check_eq("rst_dout", 32'(dout), 32'h0);
    check_eq("rst_fnum", 32'({fnumber0, fnumber1, fnumber2}), 32'h0);
    check_eq("rst_keyon", 32'(keyon), 32'h0);

    wr_pair(8'hA4, 8'h24);
    check_eq("f0_after_a4", 32'(fnumber0), 32'h0);
    wr_pair(8'hA0, 8'h0E);
    check_eq("f0_40e", 32'(fnumber0), 32'h40E);
    check_eq("blk0_4", 32'(block0), 32'h4);
    check_eq("f1_untouched", 32'({fnumber1, fnumber2}), 32'h0);

    wr_pair(8'h31, 8'h71);
    check_eq("mul1_1", 32'(multiple1), 32'h1);
    wr_pair(8'h28, 8'h12);
    check_eq("key_12", 32'(keyon), 32'h4);
    bus_wr(1'b1, 8'h13, 1, 1'b1);
    idle(20);
    check_eq("key_13", 32'(keyon), 32'h4);
    bus_wr(1'b1, 8'h02, 1, 1'b1);
    idle(20);
    check_eq("key_02", 32'(keyon), 32'h0);

    bus_wr(1'b0, 8'h30, 1, 1'b1);
    idle(2);
    busy_seen = 0;
    bus_wr(1'b1, 8'h09, 1, 1'b1);
    bus_wr(1'b1, 8'h05, 1, 1'b1);
    idle(30);
    check_eq("mul0_drop", 32'(multiple0), BusyEn ? 32'h9 : 32'h5);
    check_eq("busy_len", 32'(busy_seen), BusyEn ? 32'(Busy) : 32'h0);

    bus_wr(1'b0, 8'h32, 1, 1'b1);
    idle(2);
    busy_seen = 0;
    bus_wr(1'b1, 8'h0C, 10, 1'b1);
    idle(30);
    check_eq("mul2_hold", 32'(multiple2), 32'hC);
    check_eq("busy_hold", 32'(busy_seen), BusyEn ? 32'(Busy) : 32'h0);

    wr_pair(8'hA6, 8'h01);
    bus_wr(1'b0, 8'hA2, 1, 1'b1);
    idle(2);
    bus_wr(1'b1, 8'h23, 1, 1'b1);
    idle(3);
    check_eq("f2_123", 32'(fnumber2), 32'h123);
    check_eq("busy_pre_rst", 32'(dout), BusyEn ? 32'h80 : 32'h0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_dout", 32'(dout), 32'h0);
    check_eq("async_f2", 32'(fnumber2), 32'h0);
    m_reset();
    cs_n = 1'b0;
    a0   = 1'b1;
    din  = 8'h55;
    wr_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    busy_seen = 0;
    idle(5);
    check_eq("held_low_no_evt", 32'(busy_seen), 32'h0);
    wr_n = 1'b1;
    cs_n = 1'b1;
    idle(3);

    for (int n = 0; n < 150; n++) begin
      bit         wa0;
      logic [7:0] d;
      wa0 = 1'($urandom);
      d   = wa0 ? 8'($urandom) : addr_tab[$urandom_range(0, 11)];
      bus_wr(wa0, d, int'($urandom_range(1, 3)), $urandom_range(0, 7) != 0);
      idle(int'($urandom_range(0, 22)));
    end
    idle(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
